// File: rtl/mult_tb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mult_tb_pkg
//  Purpose : Shared definitions for the two-copy multiplier timing-leak
//            harness. Holds the driver FSM encoding, the 32-bit LFSR
//            polynomial and step function, and the default timeout formula.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package mult_tb_pkg;

    localparam int LFSR_W = 32;

    // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form. A set bit in
    // the mask flips the matching state bit when the output bit (bit 0) is 1.
    localparam logic [LFSR_W-1:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEED   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_FIRE   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_CHECK  = 3'd5,
        ST_FINISH = 3'd6
    } driverState_t;

    // Enough headroom for a bit-serial multiplier of the given operand width.
    function automatic int defaultTimeout(input int width);
        return 4 * width + 16;
    endfunction

    // One Galois step of the LFSR.
    function automatic logic [LFSR_W-1:0] lfsrNext(input logic [LFSR_W-1:0] s);
        return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_POLY : '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_lfsr32.sv
`default_nettype none
// ============================================================================
//  Module  : mult_lfsr32
//  Purpose : 32-bit Galois LFSR that advances two steps per enabled cycle
//            and exposes both intermediate values, so one cycle can supply a
//            multiplier word and a multiplicand word.
//  Ports   : clk        clock
//            rst        asynchronous reset, active-high (state cleared)
//            i_load     load the seed (takes priority over i_step)
//            i_seed     seed value; zero is replaced by 1
//            i_step     advance the state by two steps
//            o_wordOne  state after one step  (multiplier word)
//            o_wordTwo  state after two steps (multiplicand word)
//  Rev     : 1.0  initial release
// ============================================================================
module mult_lfsr32
    import mult_tb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_step,
    output logic [LFSR_W-1:0] o_wordOne,
    output logic [LFSR_W-1:0] o_wordTwo
);

    logic [LFSR_W-1:0] r_state;
    logic [LFSR_W-1:0] w_seedSafe;

    // An all-zero state is a fixed point of the LFSR, so never load it.
    assign w_seedSafe = (i_seed == '0) ? LFSR_W'(1) : i_seed;

    assign o_wordOne = lfsrNext(r_state);
    assign o_wordTwo = lfsrNext(o_wordOne);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= w_seedSafe;
        end else if (i_step) begin
            r_state <= o_wordTwo;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_leak_driver.sv
`default_nettype none
// ============================================================================
//  Module  : mult_leak_driver
//  Purpose : Initiator side of the two-copy constant-time multiplier leak
//            harness. Per trial it fills both copies with independent
//            pseudo-random operands, fires a shared start, times each done
//            and compares the latencies. The first mismatch is recorded in
//            sticky result registers; every campaign runs all trials.
//  Ports   : clk, rst                   clock, async active-high reset
//            run                        start a campaign (only when idle)
//            seed_one, seed_two         LFSR seeds per copy
//            mult_start                 one-cycle start to both copies
//            multiplier_*/multiplicand_* operands per copy
//            done_one, done_two         level done from each copy
//            busy, campaign_done        campaign status / end pulse
//            leak_found, leak_trial     first leaking trial
//            lat_one, lat_two           latencies of that trial
//            timeout_err                some trial hit the timeout
//            trials_done                trials completed this campaign
//  Rev     : 1.0  initial release
// ============================================================================
module mult_leak_driver
    import mult_tb_pkg::*;
#(
    parameter int WIDTH      = 1024,
    parameter int NUM_TRIALS = 16,
    parameter int TIMEOUT    = defaultTimeout(WIDTH),
    parameter int LAT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [31:0]      seed_one,
    input  logic [31:0]      seed_two,
    output logic             mult_start,
    output logic [WIDTH-1:0] multiplier_one,
    output logic [WIDTH-1:0] multiplicand_one,
    output logic [WIDTH-1:0] multiplier_two,
    output logic [WIDTH-1:0] multiplicand_two,
    input  logic             done_one,
    input  logic             done_two,
    output logic             busy,
    output logic             campaign_done,
    output logic             leak_found,
    output logic [15:0]      leak_trial,
    output logic [LAT_W-1:0] lat_one,
    output logic [LAT_W-1:0] lat_two,
    output logic             timeout_err,
    output logic [15:0]      trials_done
);

    localparam int                LOAD_WORDS = WIDTH / LFSR_W;
    localparam int                LOAD_CW    = (LOAD_WORDS > 1) ? $clog2(LOAD_WORDS) : 1;
    localparam logic [LOAD_CW-1:0] c_LOAD_LAST = LOAD_CW'(LOAD_WORDS - 1);
    localparam logic [LAT_W-1:0]   c_TIMEOUT   = LAT_W'(TIMEOUT);
    localparam logic [15:0]        c_TRIALS    = 16'(NUM_TRIALS);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    driverState_t       r_state;
    driverState_t       w_nextState;

    logic [LOAD_CW-1:0] r_loadCnt;
    logic [LAT_W-1:0]   r_cnt;
    logic               r_capOne;
    logic               r_capTwo;
    logic [LAT_W-1:0]   r_curLatOne;
    logic [LAT_W-1:0]   r_curLatTwo;

    logic               r_leakFound;
    logic [15:0]        r_leakTrial;
    logic [LAT_W-1:0]   r_latOne;
    logic [LAT_W-1:0]   r_latTwo;
    logic               r_timeoutErr;
    logic [15:0]        r_trialsDone;

    logic [WIDTH-1:0]   r_multiplierOne;
    logic [WIDTH-1:0]   r_multiplicandOne;
    logic [WIDTH-1:0]   r_multiplierTwo;
    logic [WIDTH-1:0]   r_multiplicandTwo;

    logic [LFSR_W-1:0]  w_wordOneA;
    logic [LFSR_W-1:0]  w_wordOneB;
    logic [LFSR_W-1:0]  w_wordTwoA;
    logic [LFSR_W-1:0]  w_wordTwoB;

    logic               w_lfsrLoad;
    logic               w_lfsrStep;
    logic               w_gotOne;
    logic               w_gotTwo;
    logic               w_lastTrial;

    assign w_lfsrLoad  = (r_state == ST_SEED);
    assign w_lfsrStep  = (r_state == ST_LOAD);

    // A copy counts as captured if it was already latched or reports done
    // in this very cycle; both may complete together.
    assign w_gotOne    = r_capOne | done_one;
    assign w_gotTwo    = r_capTwo | done_two;
    assign w_lastTrial = ((r_trialsDone + 16'd1) == c_TRIALS);

    // ------------------------------------------------------------------
    // Operand generators, one per multiplier copy
    // ------------------------------------------------------------------
    mult_lfsr32 u_lfsrOne (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_lfsrLoad),
        .i_seed    (seed_one),
        .i_step    (w_lfsrStep),
        .o_wordOne (w_wordOneA),
        .o_wordTwo (w_wordOneB)
    );

    mult_lfsr32 u_lfsrTwo (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_lfsrLoad),
        .i_seed    (seed_two),
        .i_step    (w_lfsrStep),
        .o_wordOne (w_wordTwoA),
        .o_wordTwo (w_wordTwoB)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:   if (run) w_nextState = ST_SEED;
            ST_SEED:   w_nextState = ST_LOAD;
            ST_LOAD:   if (r_loadCnt == c_LOAD_LAST) w_nextState = ST_FIRE;
            ST_FIRE:   w_nextState = ST_WAIT;
            ST_WAIT:   if ((w_gotOne && w_gotTwo) || (r_cnt == c_TIMEOUT)) w_nextState = ST_CHECK;
            ST_CHECK:  w_nextState = w_lastTrial ? ST_FINISH : ST_LOAD;
            ST_FINISH: w_nextState = ST_IDLE;
            default:   w_nextState = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        mult_start    = 1'b0;
        busy          = 1'b0;
        campaign_done = 1'b0;
        case (r_state)
            ST_IDLE:   busy = 1'b0;
            ST_FIRE:   begin mult_start = 1'b1; busy = 1'b1; end
            ST_FINISH: campaign_done = 1'b1;
            default:   busy = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operands, latency timing and result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_loadCnt         <= '0;
            r_cnt             <= '0;
            r_capOne          <= 1'b0;
            r_capTwo          <= 1'b0;
            r_curLatOne       <= '0;
            r_curLatTwo       <= '0;
            r_leakFound       <= 1'b0;
            r_leakTrial       <= '0;
            r_latOne          <= '0;
            r_latTwo          <= '0;
            r_timeoutErr      <= 1'b0;
            r_trialsDone      <= '0;
            r_multiplierOne   <= '0;
            r_multiplicandOne <= '0;
            r_multiplierTwo   <= '0;
            r_multiplicandTwo <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_leakFound  <= 1'b0;
                        r_leakTrial  <= '0;
                        r_latOne     <= '0;
                        r_latTwo     <= '0;
                        r_timeoutErr <= 1'b0;
                        r_trialsDone <= '0;
                        r_loadCnt    <= '0;
                    end
                end

                ST_LOAD: begin
                    // New words enter at the bottom, so the first word
                    // generated ends up in the most significant position.
                    r_multiplierOne   <= (r_multiplierOne   << LFSR_W) | WIDTH'(w_wordOneA);
                    r_multiplicandOne <= (r_multiplicandOne << LFSR_W) | WIDTH'(w_wordOneB);
                    r_multiplierTwo   <= (r_multiplierTwo   << LFSR_W) | WIDTH'(w_wordTwoA);
                    r_multiplicandTwo <= (r_multiplicandTwo << LFSR_W) | WIDTH'(w_wordTwoB);
                    r_loadCnt         <= (r_loadCnt == c_LOAD_LAST) ? '0 : r_loadCnt + 1'b1;
                end

                ST_FIRE: begin
                    // The first WAIT cycle reads as latency 1.
                    r_cnt       <= LAT_W'(1);
                    r_capOne    <= 1'b0;
                    r_capTwo    <= 1'b0;
                    r_curLatOne <= '0;
                    r_curLatTwo <= '0;
                end

                ST_WAIT: begin
                    if (done_one && !r_capOne) begin
                        r_capOne    <= 1'b1;
                        r_curLatOne <= r_cnt;
                    end
                    if (done_two && !r_capTwo) begin
                        r_capTwo    <= 1'b1;
                        r_curLatTwo <= r_cnt;
                    end
                    if (!(w_gotOne && w_gotTwo)) begin
                        if (r_cnt == c_TIMEOUT) begin
                            // A copy that never answered is charged the
                            // full timeout so the compare still sees it.
                            r_timeoutErr <= 1'b1;
                            if (!w_gotOne) r_curLatOne <= c_TIMEOUT;
                            if (!w_gotTwo) r_curLatTwo <= c_TIMEOUT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                ST_CHECK: begin
                    r_trialsDone <= r_trialsDone + 16'd1;
                    // Only the first mismatch is reported; later ones are
                    // still timed but leave the recorded result untouched.
                    if ((r_curLatOne != r_curLatTwo) && !r_leakFound) begin
                        r_leakFound <= 1'b1;
                        r_leakTrial <= r_trialsDone;
                        r_latOne    <= r_curLatOne;
                        r_latTwo    <= r_curLatTwo;
                    end
                end

                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign multiplier_one   = r_multiplierOne;
    assign multiplicand_one = r_multiplicandOne;
    assign multiplier_two   = r_multiplierTwo;
    assign multiplicand_two = r_multiplicandTwo;
    assign leak_found       = r_leakFound;
    assign leak_trial       = r_leakTrial;
    assign lat_one          = r_latOne;
    assign lat_two          = r_latTwo;
    assign timeout_err      = r_timeoutErr;
    assign trials_done      = r_trialsDone;

endmodule
`default_nettype wire

// File: tb/tb_mult_leak_driver.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mult_leak_driver
//  Purpose : Self-checking bench for mult_leak_driver. Two behavioural
//            multiplier models answer each start after a per-trial
//            programmable latency (0 = never). Expected campaign results are
//            computed from the latency tables and queued at run time, then
//            popped and compared when the campaign ends.
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mult_leak_driver;

    localparam int WIDTH = 64;
    localparam int NT    = 4;
    localparam int TMO   = 100;
    localparam int LAT_W = 16;
    localparam int WORDS = WIDTH / 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic [31:0]      seedOne;
    logic [31:0]      seedTwo;
    logic             mult_start;
    logic [WIDTH-1:0] multiplier_one;
    logic [WIDTH-1:0] multiplicand_one;
    logic [WIDTH-1:0] multiplier_two;
    logic [WIDTH-1:0] multiplicand_two;
    logic             doneOne;
    logic             doneTwo;
    logic             busy;
    logic             campaign_done;
    logic             leak_found;
    logic [15:0]      leak_trial;
    logic [LAT_W-1:0] lat_one;
    logic [LAT_W-1:0] lat_two;
    logic             timeout_err;
    logic [15:0]      trials_done;

    always #5 clk = ~clk;

    mult_leak_driver #(
        .WIDTH      (WIDTH),
        .NUM_TRIALS (NT),
        .TIMEOUT    (TMO),
        .LAT_W      (LAT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .run              (run),
        .seed_one         (seedOne),
        .seed_two         (seedTwo),
        .mult_start       (mult_start),
        .multiplier_one   (multiplier_one),
        .multiplicand_one (multiplicand_one),
        .multiplier_two   (multiplier_two),
        .multiplicand_two (multiplicand_two),
        .done_one         (doneOne),
        .done_two         (doneTwo),
        .busy             (busy),
        .campaign_done    (campaign_done),
        .leak_found       (leak_found),
        .leak_trial       (leak_trial),
        .lat_one          (lat_one),
        .lat_two          (lat_two),
        .timeout_err      (timeout_err),
        .trials_done      (trials_done)
    );

    // ------------------------------------------------------------------
    // Multiplier models
    // ------------------------------------------------------------------
    int progOne [NT];
    int progTwo [NT];
    int startBase = 0;
    int startTotal = 0;
    int campDoneTotal = 0;
    int mIdx;
    int cntOne = 0, cntTwo = 0, tgtOne = 0, tgtTwo = 0;

    assign mIdx = (startTotal - startBase) % NT;

    always @(posedge clk) begin
        startTotal    <= startTotal + (mult_start ? 1 : 0);
        campDoneTotal <= campDoneTotal + (campaign_done ? 1 : 0);
        if (rst) begin
            doneOne <= 1'b0; doneTwo <= 1'b0; cntOne <= 0; cntTwo <= 0;
        end else if (mult_start) begin
            tgtOne  <= progOne[mIdx];
            tgtTwo  <= progTwo[mIdx];
            cntOne  <= 1;
            cntTwo  <= 1;
            doneOne <= (progOne[mIdx] == 1);
            doneTwo <= (progTwo[mIdx] == 1);
        end else begin
            if (cntOne != 0 && !doneOne) begin
                cntOne <= cntOne + 1;
                if (tgtOne != 0 && cntOne + 1 == tgtOne) doneOne <= 1'b1;
            end
            if (cntTwo != 0 && !doneTwo) begin
                cntTwo <= cntTwo + 1;
                if (tgtTwo != 0 && cntTwo + 1 == tgtTwo) doneTwo <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard and checking helpers
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        leak;
        logic [15:0] trial;
        logic [15:0] l1;
        logic [15:0] l2;
        logic        tmo;
        logic [15:0] trials;
    } exp_t;

    exp_t expQ[$];
    int   passCnt = 0;
    int   totalCnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] gStep(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Operands of the first trial for a given seed.
    task automatic goldOps(input logic [31:0] seed, output logic [63:0] mul, output logic [63:0] mc);
        logic [31:0] s;
        s   = (seed == 32'h0) ? 32'h1 : seed;
        mul = '0;
        mc  = '0;
        for (int w = 0; w < WORDS; w++) begin
            s   = gStep(s);
            mul = (mul << 32) | 64'(s);
            s   = gStep(s);
            mc  = (mc << 32) | 64'(s);
        end
    endtask

    function automatic exp_t expected();
        exp_t e;
        int   a, b;
        e = '0;
        for (int i = 0; i < NT; i++) begin
            a = (progOne[i] == 0 || progOne[i] > TMO) ? TMO : progOne[i];
            b = (progTwo[i] == 0 || progTwo[i] > TMO) ? TMO : progTwo[i];
            if (a == TMO && progOne[i] != TMO) e.tmo = 1'b1;
            if (b == TMO && progTwo[i] != TMO) e.tmo = 1'b1;
            if (a != b && !e.leak) begin
                e.leak  = 1'b1;
                e.trial = 16'(i);
                e.l1    = 16'(a);
                e.l2    = 16'(b);
            end
        end
        e.trials = 16'(NT);
        return e;
    endfunction

    task automatic setProgs(input int a0, a1, a2, a3, b0, b1, b2, b3);
        progOne[0] = a0; progOne[1] = a1; progOne[2] = a2; progOne[3] = a3;
        progTwo[0] = b0; progTwo[1] = b1; progTwo[2] = b2; progTwo[3] = b3;
    endtask

    task automatic startCampaign(input bit pushExp);
        @(negedge clk);
        startBase = startTotal;
        if (pushExp) expQ.push_back(expected());
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic waitStarts(input string tag, input int n);
        int k;
        k = 0;
        while ((startTotal - startBase) < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_start_seen"}, 64'(startTotal - startBase >= n), 64'd1);
    endtask

    task automatic finishCampaign(input string tag);
        exp_t e;
        int   k;
        k = 0;
        while (!campaign_done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_campaign_done"}, 64'(campaign_done), 64'd1);
        e = expQ.pop_front();
        check({tag, "_busy"},        64'(busy),        64'd0);
        check({tag, "_leak_found"},  64'(leak_found),  64'(e.leak));
        check({tag, "_leak_trial"},  64'(leak_trial),  64'(e.trial));
        check({tag, "_lat_one"},     64'(lat_one),     64'(e.l1));
        check({tag, "_lat_two"},     64'(lat_two),     64'(e.l2));
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'(e.tmo));
        check({tag, "_trials_done"}, 64'(trials_done), 64'(e.trials));
        check({tag, "_starts"},      64'(startTotal - startBase), 64'(NT));
        @(negedge clk);
        check({tag, "_done_pulse"},  64'(campaign_done), 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    logic [63:0] gMul, gMc, gMul2, gMc2;
    int          campBase;

    initial begin
        rst     = 1'b1;
        run     = 1'b0;
        seedOne = 32'hACE1_2345;
        seedTwo = 32'h1357_9BDF;
        setProgs(40, 40, 40, 40, 40, 40, 40, 40);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy",        64'(busy),          64'd0);
        check("rst_start",       64'(mult_start),    64'd0);
        check("rst_leak",        64'(leak_found),    64'd0);
        check("rst_trials",      64'(trials_done),   64'd0);
        check("rst_mul_one",     multiplier_one,     64'd0);
        check("rst_mcand_two",   multiplicand_two,   64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: matched latencies, operands from the golden LFSR model
        startCampaign(1'b1);
        check("t1_busy", 64'(busy), 64'd1);
        waitStarts("t1", 1);
        goldOps(seedOne, gMul, gMc);
        goldOps(seedTwo, gMul2, gMc2);
        check("t1_mul_one",   multiplier_one,   gMul);
        check("t1_mcand_one", multiplicand_one, gMc);
        check("t1_mul_two",   multiplier_two,   gMul2);
        check("t1_mcand_two", multiplicand_two, gMc2);
        finishCampaign("t1");

        // 2: copy two one cycle slower on trial 2 only
        setProgs(40, 40, 40, 40, 40, 40, 41, 40);
        startCampaign(1'b1);
        finishCampaign("t2");

        // 3: copy one never answers
        setProgs(0, 0, 0, 0, 40, 40, 40, 40);
        startCampaign(1'b1);
        finishCampaign("t3");

        // 4: zero seeds fall back to 1 on both copies
        seedOne = 32'h0;
        seedTwo = 32'h0;
        setProgs(25, 25, 25, 25, 25, 25, 25, 25);
        startCampaign(1'b1);
        waitStarts("t4", 1);
        goldOps(32'h1, gMul, gMc);
        check("t4_pair_mul",   multiplier_one,   multiplier_two);
        check("t4_pair_mcand", multiplicand_one, multiplicand_two);
        check("t4_nonzero",    64'(multiplier_one != '0), 64'd1);
        check("t4_first_word", 64'(multiplier_one[63:32]), 64'(gMul[63:32]));
        finishCampaign("t4");

        // 5: reset in the middle of a WAIT, then a clean campaign
        seedOne = 32'h0BAD_F00D;
        seedTwo = 32'h1234_5678;
        setProgs(40, 40, 40, 40, 40, 40, 40, 40);
        startCampaign(1'b0);
        waitStarts("t5a", 3);
        repeat (10) @(negedge clk);
        campBase = campDoneTotal;
        rst = 1'b1;
        #1;
        check("t5_rst_busy",    64'(busy),         64'd0);
        check("t5_rst_trials",  64'(trials_done),  64'd0);
        check("t5_rst_leak",    64'(leak_found),   64'd0);
        check("t5_rst_timeout", 64'(timeout_err),  64'd0);
        check("t5_rst_mul",     multiplier_one,    64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_no_done", 64'(campDoneTotal - campBase), 64'd0);
        setProgs(33, 40, 12, 7, 33, 40, 12, 9);
        startCampaign(1'b1);
        finishCampaign("t5");

        // 6: run pulsed mid-campaign, both dones in the same cycle
        setProgs(30, 30, 30, 30, 30, 30, 30, 30);
        campBase = campDoneTotal;
        startCampaign(1'b1);
        waitStarts("t6", 2);
        repeat (5) @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        finishCampaign("t6");
        repeat (20) @(negedge clk);
        check("t6_one_campaign", 64'(campDoneTotal - campBase), 64'd1);
        check("t6_idle",         64'(busy),                     64'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
`default_nettype wire
